// File: rtl/game_pkg.sv
// Shared constants for the guitar-lane video path: screen geometry, pixel tag format, colours, lane table.
package game_pkg;

    localparam int unsigned SCREEN_W = 1024;
    localparam int unsigned SCREEN_H = 768;
    localparam int unsigned PIXEL_W  = 13;
    localparam int unsigned RGB_W    = 12;
    localparam int unsigned HC_W     = 11;
    localparam int unsigned VC_W     = 10;
    localparam int unsigned Y_W      = 10;
    localparam int unsigned NUM_LANES = 6;

    localparam logic [RGB_W-1:0] NOTE_RGB_DEF = 12'hF00;
    localparam logic [RGB_W-1:0] LINE_RGB_DEF = 12'h888;

    typedef struct packed {
        logic             use_px;
        logic [RGB_W-1:0] rgb;
    } pixel_t;

    // Left x of each string lane, evenly spaced from x=128 with a 96-pixel pitch.
    function automatic int unsigned lane_x(input int unsigned idx);
        return 128 + (idx % NUM_LANES) * 96;
    endfunction

endpackage

// File: rtl/note_lane_renderer_if.sv
// Raster timing, player events and tagged-pixel/judgement outputs of one string lane.
interface note_lane_renderer_if;
    import game_pkg::*;

    logic [HC_W-1:0]    hcount;
    logic [VC_W-1:0]    vcount;
    logic               vsync;
    logic               blank;
    logic               spawn;
    logic               strum;
    logic [PIXEL_W-1:0] string_pixel;
    logic               hit;
    logic               miss;
    logic               drop;

    modport master (
        output hcount, vcount, vsync, blank, spawn, strum,
        input  string_pixel, hit, miss, drop
    );

    modport slave (
        input  hcount, vcount, vsync, blank, spawn, strum,
        output string_pixel, hit, miss, drop
    );

endinterface

// File: rtl/note_slot.sv
// One falling-gem slot: active flag and top y, with load/clear/advance and per-pixel hit tests.
module note_slot
    import game_pkg::*;
#(
    parameter int unsigned LANE_X  = 128,
    parameter int unsigned LANE_W  = 64,
    parameter int unsigned NOTE_H  = 16,
    parameter int unsigned SPEED   = 4,
    parameter int unsigned HIT_Y   = 700,
    parameter int unsigned HIT_WIN = 24
) (
    input  logic            clk65,
    input  logic            rst,
    input  logic            advance,
    input  logic            clear,
    input  logic            load,
    input  logic [HC_W-1:0] hcount,
    input  logic [VC_W-1:0] vcount,
    output logic            active,
    output logic            gem_hit_c,
    output logic            in_window_c,
    output logic            offscreen_c
);

    logic [Y_W-1:0]     y_q;
    logic [HC_W-1:0]    y_ext;
    logic [HC_W-1:0]    y_adv;
    logic [HC_W-1:0]    v_ext;
    logic signed [HC_W-1:0] dy;

    assign y_ext = HC_W'(y_q);
    assign v_ext = HC_W'(vcount);
    assign y_adv = y_ext + HC_W'(SPEED);
    assign dy    = $signed(y_ext) - $signed(HC_W'(HIT_Y));

    assign offscreen_c = active && advance && (y_adv >= HC_W'(SCREEN_H));
    assign in_window_c = active && (dy >= -$signed(HC_W'(HIT_WIN)))
                                && (dy <=  $signed(HC_W'(HIT_WIN)));
    assign gem_hit_c   = active
                       && (hcount >= HC_W'(LANE_X)) && (hcount < HC_W'(LANE_X + LANE_W))
                       && (v_ext >= y_ext) && (v_ext < y_ext + HC_W'(NOTE_H));

    // Load beats clear beats advance; a strummed slot never also counts as off-screen.
    always_ff @(posedge clk65) begin
        if (rst) begin
            active <= 1'b0;
            y_q    <= '0;
        end else if (load) begin
            active <= 1'b1;
            y_q    <= '0;
        end else if (clear || offscreen_c) begin
            active <= 1'b0;
        end else if (advance && active) begin
            y_q    <= y_adv[Y_W-1:0];
        end
    end

endmodule

// File: rtl/note_lane_renderer.sv
// One guitar-string lane: gem slots, strum judgement and a 2-stage tagged-pixel pipeline.
module note_lane_renderer
    import game_pkg::*;
#(
    parameter int unsigned      LANE_X    = 128,
    parameter int unsigned      LANE_W    = 64,
    parameter int unsigned      NOTE_H    = 16,
    parameter int unsigned      MAX_NOTES = 8,
    parameter int unsigned      SPEED     = 4,
    parameter int unsigned      HIT_Y     = 700,
    parameter int unsigned      HIT_WIN   = 24,
    parameter logic [RGB_W-1:0] NOTE_RGB  = NOTE_RGB_DEF,
    parameter logic [RGB_W-1:0] LINE_RGB  = LINE_RGB_DEF
) (
    input  logic                 clk65,
    input  logic                 rst,
    note_lane_renderer_if.slave  bus
);

    logic                 vsync_q;
    logic                 adv_c;
    logic [MAX_NOTES-1:0] active;
    logic [MAX_NOTES-1:0] gem_hit;
    logic [MAX_NOTES-1:0] in_window;
    logic [MAX_NOTES-1:0] offscreen;
    logic [MAX_NOTES-1:0] load_c;
    logic [MAX_NOTES-1:0] clear_c;
    logic                 found_free_c;
    logic                 found_win_c;
    logic                 gem_q;
    logic                 line_q;
    logic                 blank_q;

    assign adv_c = bus.vsync && !vsync_q;

    for (genvar i = 0; i < int'(MAX_NOTES); i++) begin : g_slot
        note_slot #(
            .LANE_X (LANE_X),
            .LANE_W (LANE_W),
            .NOTE_H (NOTE_H),
            .SPEED  (SPEED),
            .HIT_Y  (HIT_Y),
            .HIT_WIN(HIT_WIN)
        ) u_slot (
            .clk65      (clk65),
            .rst        (rst),
            .advance    (adv_c),
            .clear      (clear_c[i]),
            .load       (load_c[i]),
            .hcount     (bus.hcount),
            .vcount     (bus.vcount),
            .active     (active[i]),
            .gem_hit_c  (gem_hit[i]),
            .in_window_c(in_window[i]),
            .offscreen_c(offscreen[i])
        );
    end

    // Lowest-index priority for both strum target and spawn slot, both judged on pre-update state.
    always_comb begin
        load_c       = '0;
        clear_c      = '0;
        found_free_c = 1'b0;
        found_win_c  = 1'b0;
        for (int i = 0; i < int'(MAX_NOTES); i++) begin
            if (!found_win_c && in_window[i]) begin
                clear_c[i]  = bus.strum;
                found_win_c = 1'b1;
            end
            if (!found_free_c && !active[i]) begin
                load_c[i]    = bus.spawn;
                found_free_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk65) begin
        if (rst) begin
            vsync_q          <= 1'b0;
            bus.hit          <= 1'b0;
            bus.miss         <= 1'b0;
            bus.drop         <= 1'b0;
            gem_q            <= 1'b0;
            line_q           <= 1'b0;
            blank_q          <= 1'b0;
            bus.string_pixel <= '0;
        end else begin
            vsync_q  <= bus.vsync;
            bus.hit  <= bus.strum && found_win_c;
            bus.miss <= (bus.strum && !found_win_c) || (|(offscreen & ~clear_c));
            bus.drop <= bus.spawn && !found_free_c;

            gem_q   <= |gem_hit;
            line_q  <= bus.hcount == HC_W'(LANE_X + LANE_W / 2);
            blank_q <= bus.blank;

            if (blank_q)     bus.string_pixel <= '0;
            else if (gem_q)  bus.string_pixel <= {1'b1, NOTE_RGB};
            else if (line_q) bus.string_pixel <= {1'b1, LINE_RGB};
            else             bus.string_pixel <= '0;
        end
    end

endmodule
